// File: rtl/mem_responder.sv
// Responder end of the per-channel valid/ready memory protocol. Each request waits
// LATENCY cycles, then competes round-robin for one single-ported storage array.
module mem_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2,
  parameter int WRITE_ENABLE = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
  input  logic [ADDR_BITS*NUM_CHANNELS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]           mem_read_ready,
  output logic [DATA_BITS*NUM_CHANNELS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
  input  logic [ADDR_BITS*NUM_CHANNELS-1:0] mem_write_address,
  input  logic [DATA_BITS*NUM_CHANNELS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]           mem_write_ready,
  input  logic                              load_enable,
  input  logic [ADDR_BITS-1:0]              load_address,
  input  logic [DATA_BITS-1:0]              load_data
);

  localparam int NUM_REQ = 2 * NUM_CHANNELS;
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W   = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Requester index: reads occupy 0..NUM_CHANNELS-1, writes NUM_CHANNELS..NUM_REQ-1.
  logic [1:0]           state_r [NUM_REQ];
  logic [CNT_W-1:0]     cnt_r   [NUM_REQ];
  logic [ADDR_BITS-1:0] addr_r  [NUM_REQ];
  logic [DATA_BITS-1:0] wdata_r [NUM_CHANNELS];
  logic [DATA_BITS-1:0] rdata_r [NUM_CHANNELS];
  logic [NUM_REQ-1:0]   ready_r;
  logic [IDX_W-1:0]     ptr_r;
  logic [DATA_BITS-1:0] mem_r   [2**ADDR_BITS];

  logic [NUM_REQ-1:0]   valid_s;
  logic [ADDR_BITS-1:0] in_addr_s [NUM_REQ];
  logic [NUM_REQ-1:0]   access_s;
  logic                 grant_any_s;
  logic [IDX_W-1:0]     grant_idx_s;
  logic [IDX_W-1:0]     ptr_next_s;
  logic                 wr_commit_s;
  logic [ADDR_BITS-1:0] wr_addr_s;
  logic [DATA_BITS-1:0] wr_data_s;

  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end
    return IDX_W'(sum);
  endfunction

  // Unpack the per-channel buses into a flat requester view and pack read data back out.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      valid_s[c]                                  = mem_read_valid[c];
      valid_s[NUM_CHANNELS+c]                     = (WRITE_ENABLE != 0) && mem_write_valid[c];
      in_addr_s[c]                                = mem_read_address[c*ADDR_BITS +: ADDR_BITS];
      in_addr_s[NUM_CHANNELS+c]                   = mem_write_address[c*ADDR_BITS +: ADDR_BITS];
      mem_read_data[c*DATA_BITS +: DATA_BITS]     = rdata_r[c];
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      access_s[i] = (state_r[i] == ST_ACCESS);
    end
  end

  assign mem_read_ready  = ready_r[NUM_CHANNELS-1:0];
  assign mem_write_ready = (WRITE_ENABLE != 0) ? ready_r[NUM_REQ-1:NUM_CHANNELS]
                                               : {NUM_CHANNELS{1'b0}};

  // Round-robin arbiter; a backdoor load owns the single port for its cycle.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = IDX_W'(0);
    if (reset && !load_enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!grant_any_s && access_s[rr_index(ptr_r, k)]) begin
          grant_any_s = 1'b1;
          grant_idx_s = rr_index(ptr_r, k);
        end else begin
          grant_idx_s = grant_idx_s;
        end
      end
    end else begin
      grant_any_s = 1'b0;
      grant_idx_s = IDX_W'(0);
    end
  end

  // Pointer advance and selection of the granted write's address/data.
  always_comb begin
    ptr_next_s  = IDX_W'(0);
    wr_commit_s = 1'b0;
    wr_addr_s   = {ADDR_BITS{1'b0}};
    wr_data_s   = {DATA_BITS{1'b0}};
    if (grant_idx_s == IDX_W'(NUM_REQ - 1)) begin
      ptr_next_s = IDX_W'(0);
    end else begin
      ptr_next_s = grant_idx_s + IDX_W'(1);
    end
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (grant_any_s && (WRITE_ENABLE != 0) && grant_idx_s == IDX_W'(NUM_CHANNELS + c)) begin
        wr_commit_s = 1'b1;
        wr_addr_s   = addr_r[NUM_CHANNELS+c];
        wr_data_s   = wdata_r[c];
      end else begin
        wr_commit_s = wr_commit_s;
      end
    end
  end

  // Storage array: never reset; loads are honoured even while reset is asserted.
  always_ff @(posedge clk) begin
    if (load_enable) begin
      mem_r[load_address] <= load_data;
    end else if (wr_commit_s) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
  end

  // Requester FSMs, ready flags, read-data capture and arbiter pointer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_r   <= IDX_W'(0);
      ready_r <= {NUM_REQ{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
        state_r[i] <= ST_IDLE;
        cnt_r[i]   <= CNT_W'(0);
        addr_r[i]  <= {ADDR_BITS{1'b0}};
      end
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        rdata_r[c] <= {DATA_BITS{1'b0}};
        wdata_r[c] <= {DATA_BITS{1'b0}};
      end
    end else begin
      if (grant_any_s) begin
        ptr_r <= ptr_next_s;
      end
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (state_r[NUM_CHANNELS+c] == ST_IDLE && valid_s[NUM_CHANNELS+c]) begin
          wdata_r[c] <= mem_write_data[c*DATA_BITS +: DATA_BITS];
        end
        if (grant_any_s && grant_idx_s == IDX_W'(c)) begin
          rdata_r[c] <= mem_r[addr_r[c]];
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        case (state_r[i])
          ST_IDLE: begin
            if (valid_s[i]) begin
              addr_r[i] <= in_addr_s[i];
              if (LATENCY == 0) begin
                state_r[i] <= ST_ACCESS;
                cnt_r[i]   <= CNT_W'(0);
              end else begin
                state_r[i] <= ST_WAIT;
                cnt_r[i]   <= CNT_W'(LATENCY);
              end
            end
          end
          ST_WAIT: begin
            cnt_r[i] <= cnt_r[i] - CNT_W'(1);
            if (cnt_r[i] <= CNT_W'(1)) begin
              state_r[i] <= ST_ACCESS;
              cnt_r[i]   <= CNT_W'(0);
            end
          end
          ST_ACCESS: begin
            if (grant_any_s && grant_idx_s == IDX_W'(i)) begin
              state_r[i] <= ST_RESP;
              ready_r[i] <= 1'b1;
            end
          end
          ST_RESP: begin
            // A dropped valid (even one dropped early) ends the response here.
            if (!valid_s[i]) begin
              state_r[i] <= ST_IDLE;
              ready_r[i] <= 1'b0;
            end
          end
          default: begin
            state_r[i] <= ST_IDLE;
            ready_r[i] <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Cycle-accurate model of the external multi-channel asynchronous memory that the GPU's memory controllers talk to: it is the responder end of the per-channel valid/ready read/write protocol. It serves up to NUM_CHANNELS concurrent requests from one controller (data or program memory). Each request incurs a fixed access latency, then competes round-robin for a single-ported storage array. A backdoor load port preloads program/data before start.

## Interface
- ADDR_BITS, 8: address width; storage depth 2^ADDR_BITS words
- DATA_BITS, 8: word width (16 when serving program memory)
- NUM_CHANNELS, 4: independent request channels
- LATENCY, 2: wait cycles between request acceptance and array arbitration (0 allowed)
- WRITE_ENABLE, 1: 0 = read-only (program memory); write ports ignored
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-low (0 = reset, sampled on clk rising edge)
- mem_read_valid  input  NUM_CHANNELS  per-channel read request
- mem_read_address  input  ADDR_BITS x NUM_CHANNELS  read address, stable while valid
- mem_read_ready  output  NUM_CHANNELS  read data valid / request complete
- mem_read_data  output  DATA_BITS x NUM_CHANNELS  read data, held while ready
- mem_write_valid  input  NUM_CHANNELS  per-channel write request
- mem_write_address  input  ADDR_BITS x NUM_CHANNELS  write address
- mem_write_data  input  DATA_BITS x NUM_CHANNELS  write data
- mem_write_ready  output  NUM_CHANNELS  write committed
- load_enable  input  1  backdoor write strobe
- load_address  input  ADDR_BITS  backdoor address
- load_data  input  DATA_BITS  backdoor data

## Operation
- 2*NUM_CHANNELS independent requester FSMs: read FSM r = channel c (index c), write FSM = channel c (index NUM_CHANNELS+c). With WRITE_ENABLE=0, write FSMs are absent; mem_write_ready constant 0.
- States: IDLE -> WAIT -> ACCESS -> RESP -> IDLE.
- IDLE: valid sampled 1 -> WAIT with cnt=LATENCY; if LATENCY=0 go directly to ACCESS. Address/data are latched at this edge; later input changes are ignored.
- WAIT: cnt decrements each edge; at edge where cnt==1 -> ACCESS.
- ACCESS: requests array; on grant, read captures mem[addr] into the channel data register, or write commits mem[addr]<=data; -> RESP.
- RESP: ready=1, data held constant. Valid sampled 0 -> IDLE, ready=0. Valid still 1 -> stay in RESP.
- Arbiter: one array access per cycle among ACCESS requesters; round-robin over index 0..2*NUM_CHANNELS-1 starting at pointer; pointer <= granted index+1 (mod). Reset pointer 0.
- load_enable=1 writes load_data to mem[load_address] at the edge and blocks arbiter grant that cycle. Load is honoured during reset.
- Read granted at edge k observes every write/load committed at edges < k; same-edge conflict impossible (single port).
- Reset: all FSMs IDLE, cnt 0, all ready 0, all mem_read_data 0, pointer 0; storage contents preserved. Reset mid-transaction aborts it silently; pending write not granted is dropped.
- Protocol violation (valid dropped in WAIT/ACCESS): transaction still completes; ready pulses until valid is seen low, which it already is, so one-cycle ready then IDLE.

## Timing
- All outputs registered; no combinational input->output path.
- Uncontended latency: valid first sampled at edge 0 -> ready high after edge LATENCY+1 (edge 1 when LATENCY=0).
- Contention adds 1 cycle per earlier grant in round-robin order; worst case 2*NUM_CHANNELS-1 extra cycles, plus 1 per load cycle.
- Ready falls at the edge after valid is sampled low; the channel is back in IDLE that same edge. A new request is accepted no earlier than the following edge (ready low ≥1 cycle between transactions).
- mem_read_data changes only on grant or reset.

## Test plan
- Reset: hold reset=0 for 2 edges with all valids high -> all ready 0, all mem_read_data 0; release -> transactions start normally.
- Single read, LATENCY=2: load mem[0x10]=0xA5; ch0 read 0x10 -> mem_read_ready[0] high after 3rd edge, data 0xA5; drop valid -> ready 0 next edge.
- Write then read: ch1 write 0x20<=0x3C, complete handshake; ch2 read 0x20 -> 0x3C; mem_write_ready[1] followed same timing as a read.
- Contention: ch0-3 read 0x00-0x03 (values 1,2,3,4) same cycle -> readies rise on 4 consecutive edges in order 0,1,2,3 with correct data; second burst starting with pointer=4 grants writes first if pending.
- Reset mid-op: reset=0 while ch0 in WAIT -> ready stays 0; after release same request completes with normal latency; storage unchanged.
- WRITE_ENABLE=0: write_valid on ch0 to 0x30 -> mem_write_ready stays 0 for 20 cycles; read 0x30 returns preloaded value.
